// File: rtl/video_stream_tx.sv
// -----------------------------------------------------------------------------
// video_stream_tx
//
// Raster video transmitter. A horizontal / vertical counter pair walks a frame
// of (H_ACTIVE + H_BLANK) x (V_ACTIVE + V_BLANK) clocks. The first V_BLANK
// lines are vertical blanking, the first VSYNC_LEN of those carry vsync.
// Within each non-blanking line the first H_ACTIVE clocks are pixel slots.
// Each slot pulls one pixel from the upstream valid/ready port. All stream
// outputs are registered one clock after the counter position they describe.
//
// Frames run back to back while tx_en is high. When tx_en drops, the frame
// in flight is completed before the block returns to idle.
//
// Build option:
//   VIDEO_STREAM_TX_COLORBAR_EN - pixels come from an internal 8-bar test
//                                 pattern. The upstream port is ignored,
//                                 pix_ready stays low and underflow never sets.
//
// Parameters:
//   H_ACTIVE   active pixels per line
//   H_BLANK    blanking clocks per line
//   V_ACTIVE   active lines per frame
//   V_BLANK    blank lines at frame start
//   VSYNC_LEN  vsync lines, 1..V_BLANK
//
// Ports:
//   clk               single clock, rising edge
//   rst_n             asynchronous active-low reset
//   tx_en             run frames while high
//   pix_valid         upstream pixel available
//   pix_data[23:0]    upstream pixel {R,G,B}
//   pix_ready         pixel slot open this cycle (combinational)
//   post_frame_vsync  frame sync, active high
//   post_frame_href   active line-and-pixel window
//   post_frame_clken  pixel strobe
//   post_img[23:0]    pixel aligned to clken, zero elsewhere
//   frame_done        one-cycle pulse on the last clock of a frame
//   underflow         sticky: a pixel slot found pix_valid low; clears at
//                     the first clock of the next frame
// -----------------------------------------------------------------------------
module video_stream_tx #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 480,
    parameter int V_BLANK   = 45,
    parameter int VSYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img,
    output logic        frame_done,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    // One spare bit of headroom so H_ACTIVE / V_BLANK constants always fit,
    // even when a blanking parameter is zero.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BLK  = VW'(V_BLANK);
    localparam logic [VW-1:0] V_SYNC = VW'(VSYNC_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic          r_vsync;
    logic          r_href;
    logic          r_clken;
    logic [23:0]   r_img;
    logic          r_frame_done;
    logic          r_underflow;

    logic          w_running;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_last;
    logic          w_origin;
    logic          w_active;
    logic [23:0]   w_pix;
    logic          w_pix_missing;

    // ------------------------------------------------------------------
    // Counter position decode
    // ------------------------------------------------------------------
    assign w_running    = (r_state != ST_IDLE);
    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_frame_last = w_h_last && w_v_last;
    assign w_origin     = w_running && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_active     = w_running && (r_v_cnt >= V_BLK) && (r_h_cnt < H_ACT);

    // ------------------------------------------------------------------
    // Pixel source
    // ------------------------------------------------------------------
`ifdef VIDEO_STREAM_TX_COLORBAR_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    int unsigned w_bar_idx;
    logic        w_unused_pix;

    // Pixels beyond the eighth full bar (H_ACTIVE not a multiple of 8) fall
    // into the default arm and stay black, matching the last bar.
    assign w_bar_idx = 32'(r_h_cnt) / BAR_W;

    // NOTE: every signal assigned in always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_pix = 24'h000000;
        case (w_bar_idx)
            0:       w_pix = 24'hFFFFFF;
            1:       w_pix = 24'hFFFF00;
            2:       w_pix = 24'h00FFFF;
            3:       w_pix = 24'h00FF00;
            4:       w_pix = 24'hFF00FF;
            5:       w_pix = 24'hFF0000;
            6:       w_pix = 24'h0000FF;
            default: w_pix = 24'h000000;
        endcase
    end

    // The upstream port is not consumed in pattern mode.
    assign w_unused_pix  = ^{pix_valid, pix_data};
    assign w_pix_missing = 1'b0;
    assign pix_ready     = 1'b0;
`else
    assign w_pix         = pix_valid ? pix_data : 24'h000000;
    assign w_pix_missing = !pix_valid;
    assign pix_ready     = w_active;
`endif

    // ------------------------------------------------------------------
    // Frame FSM, raster counters and registered stream outputs
    // ------------------------------------------------------------------
    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the
    // statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_clken      <= 1'b0;
            r_img        <= 24'h000000;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // Outputs describe the position the counters hold this cycle.
            r_vsync      <= w_running && (r_v_cnt < V_SYNC);
            r_href       <= w_active;
            r_clken      <= w_active;
            r_img        <= w_active ? w_pix : 24'h000000;
            r_frame_done <= w_running && w_frame_last;

            // (0,0) is always inside vertical blanking, so set and clear
            // can never collide on the same position.
            if (w_active && w_pix_missing) begin
                r_underflow <= 1'b1;
            end else if (w_origin) begin
                r_underflow <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                    if (tx_en) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    if (w_h_last) begin
                        r_h_cnt <= '0;
                        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                    end else begin
                        r_h_cnt <= r_h_cnt + 1'b1;
                    end

                    if (w_frame_last) begin
                        // Back-to-back frames only while RUN still sees tx_en.
                        if ((r_state == ST_DRAIN) || !tx_en) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (!tx_en) begin
                        // Once draining, a returning tx_en is ignored until
                        // the frame has finished.
                        r_state <= ST_DRAIN;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign post_frame_vsync = r_vsync;
    assign post_frame_href  = r_href;
    assign post_frame_clken = r_clken;
    assign post_img         = r_img;
    assign frame_done       = r_frame_done;
    assign underflow        = r_underflow;

endmodule

// File: tb/tb_video_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_video_stream_tx
//
// Bench for video_stream_tx on a small 12 x 7 raster (84 clocks per frame).
// Stream flags are compared every cycle against a position model; pixels
// travel through a scoreboard queue: pushed when a slot accepts (or misses) a
// pixel, popped when post_frame_clken shows it one clock later.
//
// Cycle numbering: after each rising edge the bench waits 1 ns, advances c,
// and everything visible until the next edge belongs to cycle c. An input
// set during cycle c is sampled by the edge that ends cycle c.
// -----------------------------------------------------------------------------
module tb_video_stream_tx;

    localparam int H_ACTIVE  = 8;
    localparam int H_BLANK   = 4;
    localparam int V_ACTIVE  = 4;
    localparam int V_BLANK   = 3;
    localparam int VSYNC_LEN = 1;
    localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
    localparam int FRAME     = H_TOTAL * (V_ACTIVE + V_BLANK);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic        pix_valid = 1'b1;
    logic [23:0] pix_data = 24'h000000;
    logic        pix_ready;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [23:0] post_img;
    logic        frame_done;
    logic        underflow;

    int          n_cmp = 0;
    int          n_err = 0;
    int          c = 0;
    int          slot_idx = 0;
    int          drop_slot = -1;
    int          n_clken = 0;
    logic [23:0] next_pix = 24'd1;
    logic [23:0] sb_q[$];

    always #5 clk = ~clk;

    video_stream_tx #(
        .H_ACTIVE  (H_ACTIVE),
        .H_BLANK   (H_BLANK),
        .V_ACTIVE  (V_ACTIVE),
        .V_BLANK   (V_BLANK),
        .VSYNC_LEN (VSYNC_LEN)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tx_en            (tx_en),
        .pix_valid        (pix_valid),
        .pix_data         (pix_data),
        .pix_ready        (pix_ready),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img         (post_img),
        .frame_done       (frame_done),
        .underflow        (underflow)
    );

`ifdef VIDEO_STREAM_TX_COLORBAR_EN
    function automatic logic [23:0] bar_color(int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction
`endif

    // Pixel monitor: every strobe consumes one expected pixel.
    always @(negedge clk) begin
        logic [23:0] exp_img;
        if (rst_n && post_frame_clken === 1'b1) begin
`ifdef VIDEO_STREAM_TX_COLORBAR_EN
            exp_img = bar_color(n_clken % H_ACTIVE);
            n_clken++;
            n_cmp++;
            if (post_img !== exp_img) begin
                n_err++;
                $display("FAIL bar_pixel: cycle %0d post_img=%06h expected %06h", c, post_img, exp_img);
            end
`else
            n_clken++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: cycle %0d strobe with post_img=%06h but no pixel expected", c, post_img);
            end else begin
                exp_img = sb_q.pop_front();
                n_cmp++;
                if (post_img !== exp_img) begin
                    n_err++;
                    $display("FAIL pixel: cycle %0d post_img=%06h expected %06h", c, post_img, exp_img);
                end
            end
`endif
        end
    end

    // Position model: cycle cc with first output cycle s and nf frames.
    function automatic logic slot_active(int p, int nf);
        int q;
        if (p < 0 || p >= nf * FRAME) return 1'b0;
        q = p % FRAME;
        return ((q / H_TOTAL) >= V_BLANK) && ((q % H_TOTAL) < H_ACTIVE);
    endfunction

    // {vsync, href, clken, frame_done, pix_ready, underflow, img_leak}
    function automatic logic [6:0] exp_vec(int cc, int s, int nf, int uf_lo, int uf_hi);
        int   p;
        logic vs, hr, fd, rdy, uf;
        p  = cc - s;
        vs = 1'b0;
        fd = 1'b0;
        if (p >= 0 && p < nf * FRAME) begin
            vs = ((p % FRAME) / H_TOTAL) < VSYNC_LEN;
            fd = (p % FRAME) == FRAME - 1;
        end
        hr  = slot_active(p, nf);
        rdy = slot_active(p + 1, nf);
`ifdef VIDEO_STREAM_TX_COLORBAR_EN
        rdy = 1'b0;
`endif
        uf = (cc >= uf_lo) && (cc <= uf_hi);
        return {vs, hr, hr, fd, rdy, uf, 1'b0};
    endfunction

    function automatic logic [6:0] obs();
        return {post_frame_vsync, post_frame_href, post_frame_clken, frame_done,
                pix_ready, underflow, (post_img != 24'h000000) && !post_frame_clken};
    endfunction

    // Advance one cycle and present the next upstream pixel.
    task automatic step();
        @(posedge clk);
        #1;
        c++;
        pix_data  = next_pix;
        pix_valid = (slot_idx != drop_slot);
        #1;
        if (pix_ready === 1'b1) begin
            sb_q.push_back(pix_valid ? pix_data : 24'h000000);
            if (pix_valid) next_pix++;
            slot_idx++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        sb_q.delete();
        slot_idx  = 0;
        drop_slot = -1;
        next_pix  = 24'd1;
        n_clken   = 0;
        c         = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 7'b0 || post_img !== 24'h000000) begin
            n_err++;
            $display("FAIL reset_outputs: flags=%b img=%06h expected all zero", obs(), post_img);
        end
        apply_reset();
        repeat (5) step();
        n_cmp++;
        if (obs() !== 7'b0 || post_img !== 24'h000000) begin
            n_err++;
            $display("FAIL idle_outputs: flags=%b img=%06h expected all zero", obs(), post_img);
        end
    endtask

    task automatic test_single_frame();
        logic [6:0]  e, o;
        logic [23:0] first_img;
`ifdef VIDEO_STREAM_TX_COLORBAR_EN
        first_img = 24'hFFFFFF;
`else
        first_img = 24'd1;
`endif
        apply_reset();
        for (int k = 0; k < 110; k++) begin
            step();
            if (c == 10) tx_en = 1'b1;
            if (c == 90) tx_en = 1'b0;
            e = exp_vec(c, 12, 1, -1, -2);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL single_flags: cycle %0d got %b expected %b", c, o, e);
            end
            if (c == 48) begin
                n_cmp++;
                if (post_frame_href !== 1'b1 || post_img !== first_img) begin
                    n_err++;
                    $display("FAIL first_pixel: href=%b img=%06h expected href=1 img=%06h", post_frame_href, post_img, first_img);
                end
            end
            if (c == 95) begin
                n_cmp++;
                if (frame_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL frame_done_95: got %b expected 1", frame_done);
                end
            end
        end
        n_cmp++;
        if (n_clken != 32) begin
            n_err++;
            $display("FAIL clken_count: got %0d expected 32", n_clken);
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d pixels never shown, expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e, o;
        int         fd_q[$];
        apply_reset();
        for (int k = 0; k < 280; k++) begin
            step();
            if (c == 10)  tx_en = 1'b1;
            if (c == 200) tx_en = 1'b0;
            e = exp_vec(c, 12, 3, -1, -2);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_flags: cycle %0d got %b expected %b", c, o, e);
            end
            if (frame_done === 1'b1) fd_q.push_back(c);
        end
        n_cmp++;
        if (fd_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_done_count: got %0d pulses expected 3", fd_q.size());
        end else if (fd_q[0] != 95 || fd_q[1] != 179 || fd_q[2] != 263) begin
            n_err++;
            $display("FAIL b2b_done_cycles: got %0d,%0d,%0d expected 95,179,263", fd_q[0], fd_q[1], fd_q[2]);
        end
        n_cmp++;
        if (n_clken != 96) begin
            n_err++;
            $display("FAIL b2b_clken_count: got %0d expected 96", n_clken);
        end
    endtask

`ifndef VIDEO_STREAM_TX_COLORBAR_EN
    task automatic test_underflow();
        logic [6:0] e, o;
        apply_reset();
        drop_slot = 2;
        for (int k = 0; k < 200; k++) begin
            step();
            if (c == 10)  tx_en = 1'b1;
            if (c == 120) tx_en = 1'b0;
            e = exp_vec(c, 12, 2, 50, 95);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL underflow_flags: cycle %0d got %b expected %b", c, o, e);
            end
            if (c == 50) begin
                n_cmp++;
                if (post_frame_clken !== 1'b1 || post_img !== 24'h000000) begin
                    n_err++;
                    $display("FAIL missing_pixel: clken=%b img=%06h expected clken=1 img=000000", post_frame_clken, post_img);
                end
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL underflow_sb_leftover: %0d pixels never shown, expected 0", sb_q.size());
        end
    endtask
`endif

    task automatic test_drain();
        logic [6:0] e, o;
        apply_reset();
        for (int k = 0; k < 140; k++) begin
            step();
            if (c == 10) tx_en = 1'b1;
            if (c == 50) tx_en = 1'b0;
            if (c == 70) tx_en = 1'b1;
            if (c == 72) tx_en = 1'b0;
            e = exp_vec(c, 12, 1, -1, -2);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL drain_flags: cycle %0d got %b expected %b", c, o, e);
            end
        end
        n_cmp++;
        if (n_clken != 32) begin
            n_err++;
            $display("FAIL drain_clken_count: got %0d expected 32", n_clken);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] e, o;
        int         t0;
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            step();
            if (c == 10) tx_en = 1'b1;
            e = exp_vec(c, 12, 1, -1, -2);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL prereset_flags: cycle %0d got %b expected %b", c, o, e);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 7'b0 || post_img !== 24'h000000) begin
            n_err++;
            $display("FAIL async_reset: flags=%b img=%06h expected all zero", obs(), post_img);
        end
        tx_en = 1'b0;
        sb_q.delete();
        slot_idx = 0;
        next_pix = 24'd1;
        n_clken  = 0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            o = obs();
            n_cmp++;
            if (o !== 7'b0 || post_img !== 24'h000000) begin
                n_err++;
                $display("FAIL postreset_idle: cycle %0d flags=%b img=%06h expected all zero", c, o, post_img);
            end
        end
        tx_en = 1'b1;
        t0    = c;
        for (int k = 0; k < 100; k++) begin
            step();
            if (c == t0 + 40) tx_en = 1'b0;
            e = exp_vec(c, t0 + 2, 1, -1, -2);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL restart_flags: cycle %0d got %b expected %b", c, o, e);
            end
        end
        n_cmp++;
        if (n_clken != 32) begin
            n_err++;
            $display("FAIL restart_clken_count: got %0d expected 32", n_clken);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
`ifndef VIDEO_STREAM_TX_COLORBAR_EN
        test_underflow();
`endif
        test_drain();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
